// File: rtl/int2flt_batch_seq.sv
// Batch sequencer feeding 16-bit operands through a shared int2flt engine via data_mem slots 0..3.
// Optional build macro CONV_SEQ_SKIP_ZERO_EN: zero operands bypass the converter and store 16'h0000.
module int2flt_batch_seq #(
  parameter int          NUM_OPS     = 15,
  parameter logic [7:0]  SRC_BASE    = 8'd4,
  parameter logic [7:0]  DST_BASE    = 8'd64,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [4:0] op_idx,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       cvt_req,
  input  logic       cvt_ack
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_HI, S_RD_LO, S_CAP_LO, S_WR_OP_HI, S_WR_OP_LO, S_REQ, S_MASK,
    S_WAIT_ACK, S_RS_HI, S_RS_LO, S_RS_CAP, S_WR_D_HI, S_WR_D_LO, S_DONE, S_ERR
  } state_t;

  localparam logic [4:0] LAST_K   = 5'((NUM_OPS == 0) ? 0 : NUM_OPS - 1);
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [4:0] k_q, k_d;
  logic [7:0] timer_q, timer_d;
  logic [7:0] hi_q, hi_d;
  logic [7:0] lo_q, lo_d;
  logic       error_q, error_d;

  logic [7:0] src_hi_addr, src_lo_addr, dst_hi_addr, dst_lo_addr;

  // Table addresses wrap modulo 256 by construction of the 8-bit sums.
  assign src_hi_addr = SRC_BASE + {2'b00, k_q, 1'b0};
  assign src_lo_addr = SRC_BASE + {2'b00, k_q, 1'b1};
  assign dst_hi_addr = DST_BASE + {2'b00, k_q, 1'b0};
  assign dst_lo_addr = DST_BASE + {2'b00, k_q, 1'b1};

  assign op_idx = k_q;
  assign error  = error_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      timer_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      timer_q <= timer_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    timer_d   = timer_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    error_d   = error_q;
    busy      = 1'b1;
    done      = 1'b0;
    mem_addr  = 8'h00;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = 8'h00;
    cvt_req   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          error_d = 1'b0;
          if (NUM_OPS == 0) begin
            state_d = S_DONE;
          end else begin
            k_d     = '0;
            state_d = S_RD_HI;
          end
        end
      end
      S_RD_HI: begin
        mem_rd   = 1'b1;
        mem_addr = src_hi_addr;
        state_d  = S_RD_LO;
      end
      S_RD_LO: begin
        mem_rd   = 1'b1;
        mem_addr = src_lo_addr;
        hi_d     = mem_rdata;
        state_d  = S_CAP_LO;
      end
      S_CAP_LO: begin
        lo_d    = mem_rdata;
        state_d = S_WR_OP_HI;
`ifdef CONV_SEQ_SKIP_ZERO_EN
        // Zero traps to an all-zero result; hi/lo already hold the zeros to store.
        if (hi_q == 8'h00 && mem_rdata == 8'h00) begin
          state_d = S_WR_D_HI;
        end
`endif
      end
      S_WR_OP_HI: begin
        mem_wr    = 1'b1;
        mem_addr  = 8'd0;
        mem_wdata = hi_q;
        state_d   = S_WR_OP_LO;
      end
      S_WR_OP_LO: begin
        mem_wr    = 1'b1;
        mem_addr  = 8'd1;
        mem_wdata = lo_q;
        state_d   = S_REQ;
      end
      S_REQ: begin
        cvt_req = 1'b1;
        timer_d = '0;
        state_d = S_MASK;
      end
      S_MASK: begin
        // The engine may still show the previous ack while it reacts to req.
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (cvt_ack) begin
          state_d = S_RS_HI;
        end else if (timer_q == TMO_LAST) begin
          error_d = 1'b1;
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_RS_HI: begin
        mem_rd   = 1'b1;
        mem_addr = 8'd2;
        state_d  = S_RS_LO;
      end
      S_RS_LO: begin
        mem_rd   = 1'b1;
        mem_addr = 8'd3;
        hi_d     = mem_rdata;
        state_d  = S_RS_CAP;
      end
      S_RS_CAP: begin
        lo_d    = mem_rdata;
        state_d = S_WR_D_HI;
      end
      S_WR_D_HI: begin
        mem_wr    = 1'b1;
        mem_addr  = dst_hi_addr;
        mem_wdata = hi_q;
        state_d   = S_WR_D_LO;
      end
      S_WR_D_LO: begin
        mem_wr    = 1'b1;
        mem_addr  = dst_lo_addr;
        mem_wdata = lo_q;
        if (k_q == LAST_K) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 5'd1;
          state_d = S_RD_HI;
        end
      end
      S_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_int2flt_batch_seq.sv
// Directed + randomized bench for int2flt_batch_seq with a memory model and a stub converter
// that answers ~operand five cycles after each request.
module tb_int2flt_batch_seq;

`ifdef CONV_SEQ_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int n_checks = 0;
  int n_err = 0;

  // Instance A: two operands, short timeout
  logic       start_a, busy_a, done_a, error_a, mem_rd_a, mem_wr_a, cvt_req_a;
  logic [4:0] op_idx_a;
  logic [7:0] mem_addr_a, mem_wdata_a;
  logic [7:0] mem_rdata_a;
  logic       cvt_ack_a;

  int2flt_batch_seq #(.NUM_OPS(2), .SRC_BASE(8'd4), .DST_BASE(8'd64), .ACK_TIMEOUT(10)) u_a (
    .clk(clk), .reset(rst_n), .start(start_a), .busy(busy_a), .done(done_a), .error(error_a),
    .op_idx(op_idx_a), .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_wr(mem_wr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .cvt_req(cvt_req_a), .cvt_ack(cvt_ack_a)
  );

  // Instance B: empty batch
  logic       start_b, busy_b, done_b, error_b, mem_rd_b, mem_wr_b, cvt_req_b;
  logic [4:0] op_idx_b;
  logic [7:0] mem_addr_b, mem_wdata_b;
  logic [7:0] mem_rdata_b;
  logic       cvt_ack_b;
  assign mem_rdata_b = 8'h00;
  assign cvt_ack_b   = 1'b0;

  int2flt_batch_seq #(.NUM_OPS(0)) u_b (
    .clk(clk), .reset(rst_n), .start(start_b), .busy(busy_b), .done(done_b), .error(error_b),
    .op_idx(op_idx_b), .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_wr(mem_wr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .cvt_req(cvt_req_b), .cvt_ack(cvt_ack_b)
  );

  // Memory model plus stub converter
  logic [7:0] mem [256];
  logic       tb_we;
  logic [7:0] tb_waddr, tb_wdata;
  logic       hang;
  logic [2:0] cnt;

  always @(posedge clk) begin
    if (tb_we) mem[tb_waddr] <= tb_wdata;
    if (mem_wr_a) mem[mem_addr_a] <= mem_wdata_a;
    if (mem_rd_a) mem_rdata_a <= mem[mem_addr_a];
    if (!rst_n) begin
      cvt_ack_a <= 1'b1;
      cnt       <= 3'd0;
    end else if (cvt_req_a) begin
      cvt_ack_a <= 1'b0;
      cnt       <= 3'd5;
    end else if (cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
      if (cnt == 3'd1 && !hang) begin
        mem[2]    <= ~mem[0];
        mem[3]    <= ~mem[1];
        cvt_ack_a <= 1'b1;
      end
    end
  end

  // Event monitors
  int req_cnt = 0, done_cnt = 0, req_double = 0, rdwr_both = 0, b_activity = 0;
  logic prev_req = 1'b0;
  always @(posedge clk) begin
    if (cvt_req_a) req_cnt <= req_cnt + 1;
    if (done_a) done_cnt <= done_cnt + 1;
    if (cvt_req_a && prev_req) req_double <= req_double + 1;
    if (mem_rd_a && mem_wr_a) rdwr_both <= rdwr_both + 1;
    if (mem_rd_b || mem_wr_b || cvt_req_b) b_activity <= b_activity + 1;
    prev_req <= cvt_req_a;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: result stored for one operand
  function automatic logic [15:0] exp_res(input logic [15:0] op);
    if (SKIP && op == 16'h0000) return 16'h0000;
    return ~op;
  endfunction

  function automatic int exp_reqs(input logic [15:0] op0, input logic [15:0] op1);
    int n = 0;
    if (!(SKIP && op0 == 16'h0000)) n++;
    if (!(SKIP && op1 == 16'h0000)) n++;
    return n;
  endfunction

  function automatic logic [15:0] rd_word(input logic [7:0] a);
    return {mem[a], mem[a + 8'd1]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    step();
    tb_we = 1'b0;
  endtask

  task automatic load(input logic [15:0] op0, input logic [15:0] op1);
    poke(8'd4, op0[15:8]); poke(8'd5, op0[7:0]);
    poke(8'd6, op1[15:8]); poke(8'd7, op1[7:0]);
    for (int i = 64; i < 68; i++) poke(8'(i), 8'hAA);
  endtask

  task automatic pulse_start();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (!done_a && cyc < limit) begin
      step();
      cyc++;
    end
  endtask

  task automatic run_and_check(input string tag, input logic [15:0] op0, input logic [15:0] op1);
    int r0, cyc;
    load(op0, op1);
    r0 = req_cnt;
    pulse_start();
    check({tag, "_busy"}, 32'(busy_a), 32'd1);
    wait_done(300, cyc);
    check({tag, "_done"}, 32'(done_a), 32'd1);
    check({tag, "_err"}, 32'(error_a), 32'd0);
    check({tag, "_reqs"}, 32'(req_cnt - r0), 32'(exp_reqs(op0, op1)));
    check({tag, "_dst0"}, 32'(rd_word(8'd64)), 32'(exp_res(op0)));
    check({tag, "_dst1"}, 32'(rd_word(8'd66)), 32'(exp_res(op1)));
  endtask

  initial begin
    int cyc, r0, d0;
    logic [15:0] op0, op1;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; tb_we = 1'b0; hang = 1'b0;
    tb_waddr = 8'h00; tb_wdata = 8'h00;
    step(); step();
    check("rst_a_outs", 32'({busy_a, done_a, error_a, cvt_req_a, mem_rd_a, mem_wr_a, op_idx_a, mem_addr_a, mem_wdata_a}), 32'd0);
    check("rst_b_outs", 32'({busy_b, done_b, error_b, cvt_req_b, mem_rd_b, mem_wr_b, op_idx_b, mem_addr_b, mem_wdata_b}), 32'd0);
    rst_n = 1'b1;
    step();

    // Empty batch: done the cycle after start, never touches memory
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    check("b_done", 32'(done_b), 32'd1);
    check("b_busy", 32'(busy_b), 32'd0);
    step();
    check("b_done_pulse", 32'(done_b), 32'd0);

    // Basic two-operand batch
    d0 = done_cnt;
    run_and_check("basic", 16'h0001, 16'h1234);
    check("basic_busy_end", 32'(busy_a), 32'd0);
    step();
    check("basic_done_pulse", 32'(done_a), 32'd0);
    check("basic_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Zero operands
    run_and_check("zero", 16'h0000, 16'h00F0);
    run_and_check("zero2", 16'h8000, 16'h0000);

    // Randomized operands
    for (int it = 0; it < 6; it++) begin
      op0 = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      op1 = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      run_and_check("rand", op0, op1);
    end

    // Start held high across the batch and beyond
    load(16'h0102, 16'hFF00);
    r0 = req_cnt; d0 = done_cnt;
    start_a = 1'b1;
    wait_done(300, cyc);
    check("held_done1", 32'(done_a), 32'd1);
    check("held_reqs1", 32'(req_cnt - r0), 32'd2);
    step();
    check("held_idle_gap", 32'(busy_a), 32'd0);
    step();
    check("held_restart", 32'(busy_a), 32'd1);
    start_a = 1'b0;
    wait_done(300, cyc);
    check("held_done2", 32'(done_a), 32'd1);
    check("held_reqs2", 32'(req_cnt - r0), 32'd4);
    check("held_dst1", 32'(rd_word(8'd66)), 32'(exp_res(16'hFF00)));
    step();

    // Ack timeout
    load(16'h4321, 16'h5555);
    hang = 1'b1;
    d0 = done_cnt;
    pulse_start();
    cyc = 0;
    while (!cvt_req_a && cyc < 50) begin step(); cyc++; end
    check("tmo_req_seen", 32'(cvt_req_a), 32'd1);
    cyc = 0;
    while (!error_a && cyc < 100) begin step(); cyc++; end
    check("tmo_err_cycle", 32'(cyc), 32'd12);
    check("tmo_busy", 32'(busy_a), 32'd0);
    check("tmo_dst0", 32'(rd_word(8'd64)), 32'hAAAA);
    step(); step(); step();
    check("tmo_sticky", 32'(error_a), 32'd1);
    check("tmo_no_done", 32'(done_cnt - d0), 32'd0);
    hang = 1'b0;

    // Next accepted start clears error
    load(16'h0F0F, 16'h7777);
    check("tmo_sticky_idle", 32'(error_a), 32'd1);
    r0 = req_cnt;
    pulse_start();
    check("clr_err", 32'(error_a), 32'd0);

    // Reset while waiting for ack of operand 1
    cyc = 0;
    while ((req_cnt - r0) < 2 && cyc < 100) begin step(); cyc++; end
    check("rstmid_req2", 32'(req_cnt - r0), 32'd2);
    step(); step();
    rst_n = 1'b0;
    step();
    check("rstmid_outs", 32'({busy_a, done_a, error_a, cvt_req_a, mem_rd_a, mem_wr_a, op_idx_a, mem_addr_a, mem_wdata_a}), 32'd0);
    step();
    rst_n = 1'b1;
    step(); step();
    check("rstmid_dst0", 32'(rd_word(8'd64)), 32'(exp_res(16'h0F0F)));
    check("rstmid_dst1", 32'(rd_word(8'd66)), 32'hAAAA);
    check("rstmid_busy", 32'(busy_a), 32'd0);

    // Global protocol properties
    check("req_one_cycle", 32'(req_double), 32'd0);
    check("rd_wr_exclusive", 32'(rdwr_both), 32'd0);
    check("b_no_activity", 32'(b_activity), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
